// File: rtl/rf_wb_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : rf_wb_arbiter                                                 |
// | Purpose  : Owns the single GPR-file write port. W-stage pipeline writes   |
// |            always win. Multiply/divide results are queued in a small     |
// |            FIFO and drained into cycles the pipeline leaves idle.        |
// |            A busy mask of GPRs with queued writes is exported so the     |
// |            hazard unit can stall readers of those registers.             |
// | Ports    : clk, reset (async, active-low)                                |
// |            pipe_we/pipe_a3/pipe_wd/pipe_pc : W-stage write request       |
// |            md_valid/md_ready/md_a3/md_wd/md_pc : MD result handshake     |
// |            RFWe/A3/RF_WD/WPC : registered GPR write port (WPC for trace) |
// |            busy_mask : GPRs targeted by live queued entries             |
// |            fifo_cnt  : occupied FIFO slots (live or killed)              |
// | Config   : RF_WB_TRACE_EN - print one line per committed GPR write      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module rf_wb_arbiter #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pipe_we,
  input  logic [4:0]    pipe_a3,
  input  logic [31:0]   pipe_wd,
  input  logic [31:0]   pipe_pc,
  input  logic          md_valid,
  output logic          md_ready,
  input  logic [4:0]    md_a3,
  input  logic [31:0]   md_wd,
  input  logic [31:0]   md_pc,
  output logic          RFWe,
  output logic [4:0]    A3,
  output logic [31:0]   RF_WD,
  output logic [31:0]   WPC,
  output logic [31:0]   busy_mask,
  output logic [AW:0]   fifo_cnt
);

  localparam logic [AW:0] c_depth = (AW+1)'(DEPTH);

  // FIFO storage; an entry is live only while it is queued and not killed,
  // so live implies occupied and the busy mask needs no range check.
  logic          r_live [DEPTH];
  logic [4:0]    r_a3   [DEPTH];
  logic [31:0]   r_wd   [DEPTH];
  logic [31:0]   r_pc   [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_cnt;

  logic          r_rfwe;
  logic [4:0]    r_a3_out;
  logic [31:0]   r_wd_out;
  logic [31:0]   r_pc_out;

  logic          w_pipe;
  logic          w_pop;
  logic          w_push;
  logic          w_push_entry;
  logic          w_commit;
  logic [4:0]    w_nxt_a3;
  logic [31:0]   w_nxt_wd;
  logic [31:0]   w_nxt_pc;
  logic [31:0]   w_busy;

  // A write to $0 is architecturally a no-op, so it leaves the port free.
  assign w_pipe       = pipe_we && (pipe_a3 != 5'd0);
  assign w_pop        = !w_pipe && (r_cnt != '0);
  assign md_ready     = reset && (r_cnt != c_depth);
  assign w_push       = md_valid && md_ready;
  // MD results for $0 complete the handshake but never occupy a slot.
  assign w_push_entry = w_push && (md_a3 != 5'd0);

  always_comb begin
    w_nxt_a3 = r_a3[r_rd_ptr];
    w_nxt_wd = r_wd[r_rd_ptr];
    w_nxt_pc = r_pc[r_rd_ptr];
    w_commit = w_pop && r_live[r_rd_ptr];
    if (w_pipe) begin
      w_nxt_a3 = pipe_a3;
      w_nxt_wd = pipe_wd;
      w_nxt_pc = pipe_pc;
      w_commit = 1'b1;
    end
  end

  // Output stage: address/data/PC only update on a real write, otherwise hold.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rfwe   <= 1'b0;
      r_a3_out <= 5'd0;
      r_wd_out <= 32'd0;
      r_pc_out <= 32'd0;
    end else begin
      r_rfwe <= w_commit;
      if (w_commit) begin
        r_a3_out <= w_nxt_a3;
        r_wd_out <= w_nxt_wd;
        r_pc_out <= w_nxt_pc;
      end
    end
  end

  // Pointers, occupancy and live bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) r_live[i] <= 1'b0;
    end else begin
      // A younger pipeline write to the same GPR makes queued MD results stale.
      for (int i = 0; i < DEPTH; i++) begin
        if (w_pipe && r_live[i] && (r_a3[i] == pipe_a3)) r_live[i] <= 1'b0;
      end
      if (w_pop) begin
        r_live[r_rd_ptr] <= 1'b0;
        r_rd_ptr         <= r_rd_ptr + 1'b1;
      end
      // Written last: an entry enqueued on a kill edge is younger and survives.
      if (w_push_entry) begin
        r_live[r_wr_ptr] <= 1'b1;
        r_wr_ptr         <= r_wr_ptr + 1'b1;
      end
      case ({w_push_entry, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Payload storage needs no reset; it is only observed through live entries.
  always_ff @(posedge clk) begin
    if (w_push_entry) begin
      r_a3[r_wr_ptr] <= md_a3;
      r_wd[r_wr_ptr] <= md_wd;
      r_pc[r_wr_ptr] <= md_pc;
    end
  end

  always_comb begin
    w_busy = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_live[i]) w_busy[r_a3[i]] = 1'b1;
    end
    w_busy[0] = 1'b0;
  end

  assign busy_mask = w_busy;
  assign fifo_cnt  = r_cnt;
  assign RFWe      = r_rfwe;
  assign A3        = r_a3_out;
  assign RF_WD     = r_wd_out;
  assign WPC       = r_pc_out;

`ifdef RF_WB_TRACE_EN
  // Prints the values being committed on this edge.
  always_ff @(posedge clk) begin
    if (reset && w_commit) begin
      $display("%d@%h: $%d <= %h", $time, w_nxt_pc, w_nxt_a3, w_nxt_wd);
    end
  end
`endif

endmodule
`default_nettype wire
